// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: data/register widths and FSM encoding.
package pipe_ctrl_pkg;
  localparam int DATA_LEN = 32;
  localparam int REG_IDX  = 5;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERR      = 2'd2
  } state_t;
endpackage

// File: rtl/pipe_ctrl_hazard_unit.sv
// Load-use hazard detector: flags an ID instruction that reads the load destination currently in EX.
module hazard_unit
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_IDX-1:0] id_rs1_idx,
  input  logic [REG_IDX-1:0] id_rs2_idx,
  input  logic               id_rs1_used,
  input  logic               id_rs2_used,
  input  logic [REG_IDX-1:0] ex_rd_idx,
  input  logic               ex_rmem,
  output logic               load_use
);
  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit  = id_rs1_used && (id_rs1_idx == ex_rd_idx);
  assign rs2_hit  = id_rs2_used && (id_rs2_idx == ex_rd_idx);
  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign load_use = ex_rmem && (ex_rd_idx != '0) && (rs1_hit || rs2_hit);
endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: data-memory wait FSM with timeout, hazard priority, stall counter.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int                  DMEM_TIMEOUT = 255,
  parameter logic [DATA_LEN-1:0] STALL_MAX    = 32'hFFFF_FFFF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [REG_IDX-1:0]  id_rs1_idx,
  input  logic [REG_IDX-1:0]  id_rs2_idx,
  input  logic                id_rs1_used,
  input  logic                id_rs2_used,
  input  logic [REG_IDX-1:0]  ex_rd_idx,
  input  logic                ex_rmem,
  input  logic                mem_rmem,
  input  logic                mem_wmem,
  output logic                dmem_req,
  input  logic                dmem_ack,
  input  logic                ex_redirect,
  output logic                hold_pc,
  output logic                hold_if_id,
  output logic                hold_id_ex,
  output logic                hold_ex_mem,
  output logic                flush_if_id,
  output logic                flush_id_ex,
  output logic                bubble_mem_wb,
  output logic                mem_err,
  output logic [DATA_LEN-1:0] stall_cycles,
  output state_t              state
);
  localparam int WCNT_W = $clog2(DMEM_TIMEOUT + 1);

  // dmem handshake: an access completes in the cycle where dmem_req and dmem_ack
  // are both high; dmem_req stays high from the first request cycle until then.
  state_t            next_state;
  logic [WCNT_W-1:0] wait_cnt;
  logic              mem_stall;
  logic              load_use;

  hazard_unit u_hazard (
    .id_rs1_idx (id_rs1_idx),
    .id_rs2_idx (id_rs2_idx),
    .id_rs1_used(id_rs1_used),
    .id_rs2_used(id_rs2_used),
    .ex_rd_idx  (ex_rd_idx),
    .ex_rmem    (ex_rmem),
    .load_use   (load_use)
  );

  always_comb begin
    next_state    = state;
    dmem_req      = 1'b0;
    hold_pc       = 1'b0;
    hold_if_id    = 1'b0;
    hold_id_ex    = 1'b0;
    hold_ex_mem   = 1'b0;
    flush_if_id   = 1'b0;
    flush_id_ex   = 1'b0;
    bubble_mem_wb = 1'b0;

    case (state)
      ST_RUN:      dmem_req = mem_rmem || mem_wmem;
      ST_MEM_WAIT: dmem_req = 1'b1;
      default:     dmem_req = 1'b0;
    endcase
    mem_stall = dmem_req && !dmem_ack;

    case (state)
      ST_RUN:      if (mem_stall) next_state = ST_MEM_WAIT;
      ST_MEM_WAIT: begin
        if (dmem_ack) next_state = ST_RUN;
        else if (wait_cnt == WCNT_W'(DMEM_TIMEOUT)) next_state = ST_ERR;
      end
      default:     next_state = ST_ERR;
    endcase

    // Memory stall freezes everything; redirect beats load-use.
    if (mem_stall || state == ST_ERR) begin
      hold_pc       = 1'b1;
      hold_if_id    = 1'b1;
      hold_id_ex    = 1'b1;
      hold_ex_mem   = 1'b1;
      bubble_mem_wb = 1'b1;
    end else if (ex_redirect) begin
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
    end else if (load_use) begin
      hold_pc     = 1'b1;
      hold_if_id  = 1'b1;
      flush_id_ex = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_RUN;
      wait_cnt     <= '0;
      mem_err      <= 1'b0;
      stall_cycles <= '0;
    end else begin
      state <= next_state;
      if (state != ST_MEM_WAIT) wait_cnt <= '0;
      else if (wait_cnt != WCNT_W'(DMEM_TIMEOUT)) wait_cnt <= wait_cnt + 1'b1;
      if (next_state == ST_ERR) mem_err <= 1'b1;
      if (hold_pc && stall_cycles != STALL_MAX) stall_cycles <= stall_cycles + 1'b1;
    end
  end
endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized scoreboard bench for pipe_ctrl against a stall-length reference model.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int          TIMEOUT = 4;
  localparam int unsigned SAT_MAX = 200;
  localparam int          OUT_W   = 41;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  id_rs1_idx = '0, id_rs2_idx = '0, ex_rd_idx = '0;
  logic        id_rs1_used = 1'b0, id_rs2_used = 1'b0, ex_rmem = 1'b0;
  logic        mem_rmem = 1'b0, mem_wmem = 1'b0, dmem_ack = 1'b0, ex_redirect = 1'b0;
  logic        dmem_req, hold_pc, hold_if_id, hold_id_ex, hold_ex_mem;
  logic        flush_if_id, flush_id_ex, bubble_mem_wb, mem_err;
  logic [31:0] stall_cycles;
  state_t      state;

  pipe_ctrl #(.DMEM_TIMEOUT(TIMEOUT), .STALL_MAX(SAT_MAX)) dut (
    .clk(clk), .rst(rst),
    .id_rs1_idx(id_rs1_idx), .id_rs2_idx(id_rs2_idx),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rd_idx(ex_rd_idx), .ex_rmem(ex_rmem),
    .mem_rmem(mem_rmem), .mem_wmem(mem_wmem),
    .dmem_req(dmem_req), .dmem_ack(dmem_ack), .ex_redirect(ex_redirect),
    .hold_pc(hold_pc), .hold_if_id(hold_if_id), .hold_id_ex(hold_id_ex),
    .hold_ex_mem(hold_ex_mem), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .bubble_mem_wb(bubble_mem_wb), .mem_err(mem_err), .stall_cycles(stall_cycles),
    .state(state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [OUT_W-1:0] exp_q[$];

  // Reference model: an access is "open" while its un-acked stall length is non-zero;
  // error once it has gone unacknowledged for one request cycle plus TIMEOUT+1 waits.
  bit          m_err;
  int          m_stall_len;
  int unsigned m_count;

  task automatic model_reset();
    m_err = 0;
    m_stall_len = 0;
    m_count = 0;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input bit u1, input bit u2,
                       input logic [4:0] rd, input bit exr, input bit mr, input bit mw,
                       input bit ack, input bit redir);
    bit req, stall, lu, h_all, fl, lu_act;
    @(negedge clk);
    id_rs1_idx = rs1; id_rs2_idx = rs2; id_rs1_used = u1; id_rs2_used = u2;
    ex_rd_idx = rd; ex_rmem = exr; mem_rmem = mr; mem_wmem = mw;
    dmem_ack = ack; ex_redirect = redir;
    req    = !m_err && (m_stall_len > 0 || mr || mw);
    stall  = req && !ack;
    lu     = exr && rd != 0 && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    h_all  = m_err || stall;
    fl     = !h_all && redir;
    lu_act = !h_all && !redir && lu;
    exp_q.push_back({req, h_all | lu_act, h_all | lu_act, h_all, h_all,
                     fl, fl | lu_act, h_all, m_err, m_count});
    @(posedge clk);
    if (h_all || lu_act) m_count = (m_count < SAT_MAX) ? m_count + 1 : SAT_MAX;
    if (!m_err) begin
      if (stall) begin
        m_stall_len++;
        if (m_stall_len == TIMEOUT + 2) m_err = 1;
      end else begin
        m_stall_len = 0;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    id_rs1_used = 0; id_rs2_used = 0; ex_rmem = 0; mem_rmem = 0; mem_wmem = 0;
    dmem_ack = 0; ex_redirect = 0;
    #1;
    check("rst_state", 64'(state), 64'(ST_RUN));
    check("rst_mem_err", 64'(mem_err), 64'd0);
    check("rst_stall_cycles", 64'(stall_cycles), 64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: outputs are combinational, so each driven cycle presents one response.
  initial begin
    logic [OUT_W-1:0] got, want;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        got  = {dmem_req, hold_pc, hold_if_id, hold_id_ex, hold_ex_mem,
                flush_if_id, flush_id_ex, bubble_mem_wb, mem_err, stall_cycles};
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL outputs: got req/hpc/hif/hie/hem/fif/fie/bub/err=%b stall=%0d expected %b stall=%0d",
                   got[40:32], got[31:0], want[40:32], want[31:0]);
        end
      end
    end
  end

  initial begin
    model_reset();
    #1;
    check("init_state", 64'(state), 64'(ST_RUN));
    check("init_stall_cycles", 64'(stall_cycles), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Load hit with immediate ack: no stall.
    drive(0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    idle(1);
    // Store with three un-acked cycles then ack.
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    idle(1);
    check("after_store_state", 64'(state), 64'(ST_RUN));
    // Load-use on rs2, then rd=x0 (no hazard), then redirect overriding load-use.
    drive(0, 5, 0, 1, 5, 1, 0, 0, 0, 0);
    drive(0, 5, 0, 1, 0, 1, 0, 0, 0, 0);
    drive(5, 5, 1, 1, 5, 1, 0, 0, 0, 1);
    drive(3, 0, 1, 0, 3, 1, 0, 0, 0, 0);
    // Redirect arriving during a memory stall is ignored.
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(1);

    // Randomized traffic; reset whenever the model reaches the error state.
    for (int i = 0; i < 3000; i++) begin
      drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 3)), $urandom_range(0, 3) == 0,
            $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 9) < 4, $urandom_range(0, 5) == 0);
      if (m_err || $urandom_range(0, 299) == 0) do_reset();
    end

    // Timeout into the terminal error state, then let the counter saturate there.
    do_reset();
    for (int i = 0; i < 8; i++) drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    check("err_state", 64'(state), 64'(ST_ERR));
    for (int i = 0; i < int'(SAT_MAX) + 10; i++)
      drive(5'($urandom), 5'($urandom), 1, 1, 5'($urandom), 1,
            1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    idle(1);
    check("saturated", 64'(stall_cycles), 64'(SAT_MAX));
    check("err_sticky", 64'(mem_err), 64'd1);
    // Reset in the middle of a wait abandons the access.
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    do_reset();
    idle(2);
    check("post_abandon_req", 64'(dmem_req), 64'd0);

    @(negedge clk);
    #4;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: %0d entries left expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
